// File: rtl/inert_pkg.sv
// State, phase and SPI command definitions shared by the inertial-sensor sequencer.
package inert_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT = 4'd0,
    WR0      = 4'd1,
    WR1      = 4'd2,
    WR2      = 4'd3,
    IDLE     = 4'd4,
    RD_PL    = 4'd5,
    RD_PH    = 4'd6,
    RD_YL    = 4'd7,
    RD_YH    = 4'd8
  } state_t;

  typedef enum logic {
    SEND = 1'b0,
    WAIT = 1'b1
  } phase_t;

  localparam logic [15:0] CFG_INT   = 16'h0D02;
  localparam logic [15:0] CFG_GYRO  = 16'h1160;
  localparam logic [15:0] CFG_RND   = 16'h1440;
  localparam logic [15:0] RD_PTCH_L = 16'hA200;
  localparam logic [15:0] RD_PTCH_H = 16'hA300;
  localparam logic [15:0] RD_YAW_L  = 16'hA600;
  localparam logic [15:0] RD_YAW_H  = 16'hA700;

  // Command word each transaction state puts on the bus; zero when no command is active.
  function automatic logic [15:0] state_cmd(input state_t s);
    case (s)
      WR0:     return CFG_INT;
      WR1:     return CFG_GYRO;
      WR2:     return CFG_RND;
      RD_PL:   return RD_PTCH_L;
      RD_PH:   return RD_PTCH_H;
      RD_YL:   return RD_YAW_L;
      RD_YH:   return RD_YAW_H;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic state_t next_step(input state_t s);
    case (s)
      WR0:     return WR1;
      WR1:     return WR2;
      RD_PL:   return RD_PH;
      RD_PH:   return RD_YL;
      RD_YL:   return RD_YH;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/inert_spi_seq_if.sv
// Handshake between the sequencer and the 16-bit SPI monarch.
interface inert_spi_seq_if;
  logic        snd;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;

  modport master (output snd, output cmd, input done, input resp);
  modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/inert_int_sync.sv
// Brings the sensor data-ready line into the clk domain and flags its rising edge.
module inert_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic int_async,
  output logic int_rise
);

  logic [2:0] sync;

  // NOTE: clocked state uses non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], int_async};
  end

  assign int_rise = sync[1] & ~sync[2];

endmodule

// File: rtl/inert_spi_seq.sv
// Power-up/config sequencer and pitch/yaw reader for the inertial sensor's SPI monarch.
module inert_spi_seq
  import inert_pkg::*;
#(
  parameter int WAIT_BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            INT,
  inert_spi_seq_if.master spi,
  output logic [15:0]     ptch_rt,
  output logic [15:0]     yaw_rt,
  output logic            vld,
  output logic            init_done
);

  state_t               state;
  phase_t               phase;
  logic [WAIT_BITS-1:0] wait_cnt;
  logic                 pending;
  logic                 done_q;
  logic [7:0]           pl, ph, yl;
  logic                 int_rise;
  logic                 done_rise;
  logic                 in_cmd;
  logic [7:0]           resp_lo;
  logic                 unused_resp_hi;

  inert_int_sync u_int_sync (
    .clk       (clk),
    .rst       (rst),
    .int_async (INT),
    .int_rise  (int_rise)
  );

  // Only a fresh low-to-high transition of done marks completion; a held level never does.
  assign done_rise      = spi.done & ~done_q;
  assign in_cmd         = (state != PWR_WAIT) && (state != IDLE);
  assign spi.snd        = in_cmd && (phase == SEND);
  assign spi.cmd        = state_cmd(state);
  assign resp_lo        = spi.resp[7:0];
  assign unused_resp_hi = ^spi.resp[15:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWR_WAIT;
      phase     <= SEND;
      wait_cnt  <= '0;
      pending   <= 1'b0;
      done_q    <= 1'b0;
      pl        <= '0;
      ph        <= '0;
      yl        <= '0;
      ptch_rt   <= '0;
      yaw_rt    <= '0;
      vld       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      done_q <= spi.done;
      vld    <= 1'b0;

      // A new edge wins over the clear so an interrupt landing on the start cycle is kept.
      if (int_rise && init_done)         pending <= 1'b1;
      else if (state == IDLE && pending) pending <= 1'b0;

      case (state)
        PWR_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (&wait_cnt) begin
            state <= WR0;
            phase <= SEND;
          end
        end
        IDLE: begin
          if (pending) begin
            state <= RD_PL;
            phase <= SEND;
          end
        end
        default: begin
          if (phase == SEND) begin
            phase <= WAIT;
          end else if (done_rise) begin
            phase <= SEND;
            state <= next_step(state);
            case (state)
              WR2:   init_done <= 1'b1;
              RD_PL: pl <= resp_lo;
              RD_PH: ph <= resp_lo;
              RD_YL: yl <= resp_lo;
              RD_YH: begin
                // Both rates publish together so fusion logic never sees a torn pair.
                ptch_rt <= {ph, pl};
                yaw_rt  <= {resp_lo, yl};
                vld     <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inert_spi_seq.sv
// Self-checking bench: randomized SPI monarch model and a transaction-level reference for the sequencer.
module tb_inert_spi_seq;

  logic        clk;
  logic        rst;
  logic        INT;
  logic [15:0] ptch_rt;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        init_done;

  inert_spi_seq_if spi_if ();

  inert_spi_seq #(.WAIT_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (INT),
    .spi       (spi_if),
    .ptch_rt   (ptch_rt),
    .yaw_rt    (yaw_rt),
    .vld       (vld),
    .init_done (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total;
  int          bad;
  int          cyc;
  int          lat_lo;
  int          lat_hi;
  int          glitch_req;
  logic [15:0] cmd_log [$];
  logic [7:0]  byte_log [$];
  logic [7:0]  force_q [$];
  logic [31:0] res_log [$];
  int          vld_cyc [$];
  int          snd_cyc [$];
  logic [31:0] prev_out;
  logic        prev_snd;
  logic        prev_vld;

  logic [15:0] cfg_cmds [3] = '{16'h0D02, 16'h1160, 16'h1440};
  logic [15:0] rd_cmds  [4] = '{16'hA200, 16'hA300, 16'hA600, 16'hA700};

  // Monarch model: logs each command, drops done one cycle after snd, raises it after a random latency.
  initial begin : monarch
    int         cnt;
    int         lat;
    bit         busy;
    bit         gl;
    int         gack;
    logic [7:0] lo;
    spi_if.done = 1'b0;
    spi_if.resp = '0;
    busy = 0;
    gl   = 0;
    gack = 0;
    cnt  = 0;
    lat  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
        gl   = 0;
        spi_if.done = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == lat - 1) spi_if.done = 1'b0;
        if (cnt == 0) begin
          spi_if.resp = {8'($urandom), byte_log[$]};
          spi_if.done = 1'b1;
          busy = 0;
        end
      end else if (gl) begin
        spi_if.done = 1'b1;
        gl = 0;
      end else if (spi_if.snd) begin
        if (force_q.size() > 0) lo = force_q.pop_front();
        else                    lo = 8'($urandom);
        cmd_log.push_back(spi_if.cmd);
        byte_log.push_back(lo);
        lat  = $urandom_range(lat_hi, lat_lo);
        cnt  = lat;
        busy = 1;
      end else if (glitch_req != gack) begin
        gack = glitch_req;
        spi_if.done = 1'b0;
        gl = 1;
      end
    end
  end

  // Reference: a completed read group starting at log index i yields {pitch, yaw} from its four bytes.
  function automatic logic [31:0] model_pair(input int i);
    if (byte_log.size() < i + 4) return 'x;
    return {byte_log[i+1], byte_log[i], byte_log[i+3], byte_log[i+2]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (spi_if.snd) snd_cyc.push_back(cyc);
    if (vld) begin
      res_log.push_back({ptch_rt, yaw_rt});
      vld_cyc.push_back(cyc);
    end
    if (rst) begin
      total++;
      if (spi_if.snd !== 1'b0) begin
        bad++;
        $display("FAIL snd_in_reset: got %b want 0", spi_if.snd);
      end
    end else if ({ptch_rt, yaw_rt} !== prev_out) begin
      total++;
      if (vld !== 1'b1) begin
        bad++;
        $display("FAIL atomic_update: outputs changed to %h with vld=%b want vld=1", {ptch_rt, yaw_rt}, vld);
      end
    end
    if (prev_snd) begin
      total++;
      if (spi_if.snd !== 1'b0) begin
        bad++;
        $display("FAIL snd_width: snd high %0d cycles in a row, want 1", 2);
      end
    end
    if (prev_vld) begin
      total++;
      if (vld !== 1'b0) begin
        bad++;
        $display("FAIL vld_width: vld high %0d cycles in a row, want 1", 2);
      end
    end
    prev_out = {ptch_rt, yaw_rt};
    prev_snd = spi_if.snd;
    prev_vld = vld;
  endtask

  task automatic pulse_int();
    INT = 1'b1;
    step();
    step();
    INT = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    INT = 1'b0;
    repeat (3) step();
    total++;
    if (spi_if.snd !== 1'b0) begin bad++; $display("FAIL reset_snd: got %b want 0", spi_if.snd); end
    total++;
    if (spi_if.cmd !== 16'h0000) begin bad++; $display("FAIL reset_cmd: got %h want 0000", spi_if.cmd); end
    total++;
    if (ptch_rt !== 16'h0000) begin bad++; $display("FAIL reset_ptch: got %h want 0000", ptch_rt); end
    total++;
    if (yaw_rt !== 16'h0000) begin bad++; $display("FAIL reset_yaw: got %h want 0000", yaw_rt); end
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", vld); end
    total++;
    if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done: got %b want 0", init_done); end
  endtask

  task automatic test_power_up(input bit int_noise);
    int base;
    int rel;
    int first;
    bit got;
    bit pd;
    bit pi;
    base  = cmd_log.size();
    rst   = 1'b0;
    rel   = cyc;
    first = -1;
    for (int k = 0; k < 100 && first < 0; k++) begin
      if (int_noise) INT = (k >= 3 && k < 6);
      step();
      if (spi_if.snd) first = cyc;
    end
    INT = 1'b0;
    total++;
    if (first < rel + 16 || first > rel + 17) begin
      bad++;
      $display("FAIL pwr_wait: first snd at offset %0d want 16..17", first - rel);
    end
    got = 0;
    pd  = spi_if.done;
    pi  = init_done;
    for (int k = 0; k < 1000 && !got; k++) begin
      if (int_noise) INT = (cmd_log.size() == base + 2) && ((k % 8) < 3);
      step();
      if (cmd_log.size() == base + 3 && spi_if.done && !pd) begin
        got = 1;
        total++;
        if (init_done !== 1'b1 || pi !== 1'b0) begin
          bad++;
          $display("FAIL init_done_timing: before=%b after=%b want 0 then 1", pi, init_done);
        end
      end
      pd = spi_if.done;
      pi = init_done;
    end
    INT = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL init_timeout: cmds=%0d want %0d", cmd_log.size() - base, 3);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cmd_log.size() <= base + i || cmd_log[base+i] !== cfg_cmds[i]) begin
        bad++;
        $display("FAIL cfg_cmd%0d: got %h want %h", i,
                 (cmd_log.size() > base + i) ? cmd_log[base+i] : 16'hxxxx, cfg_cmds[i]);
      end
    end
    repeat (60) step();
    total++;
    if (cmd_log.size() != base + 3) begin
      bad++;
      $display("FAIL no_spurious_read: cmds=%0d want %0d", cmd_log.size() - base, 3);
    end
    total++;
    if (init_done !== 1'b1) begin bad++; $display("FAIL init_sticky: got %b want 1", init_done); end
  endtask

  task automatic test_read_known();
    int base;
    int nres;
    base = cmd_log.size();
    nres = res_log.size();
    force_q = '{8'h34, 8'h12, 8'hCD, 8'hAB};
    pulse_int();
    for (int k = 0; k < 400 && res_log.size() < nres + 1; k++) step();
    total++;
    if (res_log.size() < nres + 1) begin
      bad++;
      $display("FAIL known_timeout: results=%0d want %0d", res_log.size() - nres, 1);
    end else if (res_log[nres] !== 32'h1234ABCD) begin
      bad++;
      $display("FAIL known_result: got %h want 1234abcd", res_log[nres]);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cmd_log.size() <= base + i || cmd_log[base+i] !== rd_cmds[i]) begin
        bad++;
        $display("FAIL known_cmd%0d: got %h want %h", i,
                 (cmd_log.size() > base + i) ? cmd_log[base+i] : 16'hxxxx, rd_cmds[i]);
      end
    end
    repeat (20) step();
    total++;
    if ({ptch_rt, yaw_rt} !== 32'h1234ABCD || res_log.size() != nres + 1) begin
      bad++;
      $display("FAIL known_hold: got %h results=%0d want 1234abcd results=1", {ptch_rt, yaw_rt},
               res_log.size() - nres);
    end
  endtask

  task automatic test_random_reads();
    for (int r = 0; r < 5; r++) begin
      int base;
      int nres;
      base = cmd_log.size();
      nres = res_log.size();
      pulse_int();
      for (int k = 0; k < 400 && res_log.size() < nres + 1; k++) step();
      repeat ($urandom_range(8, 2)) step();
      total++;
      if (res_log.size() != nres + 1) begin
        bad++;
        $display("FAIL rand_count%0d: results=%0d want 1", r, res_log.size() - nres);
      end else if (res_log[nres] !== model_pair(base)) begin
        bad++;
        $display("FAIL rand_result%0d: got %h want %h", r, res_log[nres], model_pair(base));
      end
      total++;
      if (cmd_log.size() != base + 4 || cmd_log[base] !== 16'hA200 || cmd_log[base+3] !== 16'hA700) begin
        bad++;
        $display("FAIL rand_cmds%0d: count=%0d want 4 reads A200..A700", r, cmd_log.size() - base);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int nres;
    int sbase;
    base  = cmd_log.size();
    nres  = res_log.size();
    sbase = snd_cyc.size();
    pulse_int();
    for (int k = 0; k < 300 && cmd_log.size() < base + 2; k++) step();
    pulse_int();
    for (int k = 0; k < 300 && cmd_log.size() < base + 3; k++) step();
    pulse_int();
    for (int k = 0; k < 800 && res_log.size() < nres + 2; k++) step();
    repeat (80) step();
    total++;
    if (res_log.size() != nres + 2) begin
      bad++;
      $display("FAIL b2b_vld_count: got %0d want 2", res_log.size() - nres);
    end
    total++;
    if (cmd_log.size() != base + 8) begin
      bad++;
      $display("FAIL b2b_cmd_count: got %0d want 8", cmd_log.size() - base);
    end
    if (res_log.size() >= nres + 2) begin
      total++;
      if (res_log[nres] !== model_pair(base) || res_log[nres+1] !== model_pair(base + 4)) begin
        bad++;
        $display("FAIL b2b_results: got %h %h want %h %h", res_log[nres], res_log[nres+1],
                 model_pair(base), model_pair(base + 4));
      end
      total++;
      if (snd_cyc.size() < sbase + 5 || snd_cyc[sbase+4] != vld_cyc[nres] + 1) begin
        bad++;
        $display("FAIL b2b_restart: second sequence snd at %0d want %0d",
                 (snd_cyc.size() >= sbase + 5) ? snd_cyc[sbase+4] : -1, vld_cyc[nres] + 1);
      end
    end
  endtask

  task automatic test_done_level();
    int          base;
    int          nres;
    logic [31:0] held;
    base = cmd_log.size();
    nres = res_log.size();
    held = {ptch_rt, yaw_rt};
    repeat (10) step();
    glitch_req++;
    repeat (30) step();
    total++;
    if (cmd_log.size() != base || res_log.size() != nres || {ptch_rt, yaw_rt} !== held) begin
      bad++;
      $display("FAIL stray_done: cmds=%0d results=%0d out=%h want 0 0 %h",
               cmd_log.size() - base, res_log.size() - nres, {ptch_rt, yaw_rt}, held);
    end
    pulse_int();
    for (int k = 0; k < 400 && res_log.size() < nres + 1; k++) step();
    repeat (30) step();
    total++;
    if (res_log.size() != nres + 1 || cmd_log.size() != base + 4) begin
      bad++;
      $display("FAIL level_done_count: results=%0d cmds=%0d want 1 4",
               res_log.size() - nres, cmd_log.size() - base);
    end else if (res_log[nres] !== model_pair(base)) begin
      bad++;
      $display("FAIL level_done_result: got %h want %h", res_log[nres], model_pair(base));
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int nres;
    base = cmd_log.size();
    pulse_int();
    for (int k = 0; k < 300 && cmd_log.size() < base + 3; k++) step();
    step();
    step();
    rst = 1'b1;
    #1;
    total++;
    if (spi_if.snd !== 1'b0 || init_done !== 1'b0 || vld !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_ctrl: snd=%b init_done=%b vld=%b want 0 0 0", spi_if.snd, init_done, vld);
    end
    total++;
    if (ptch_rt !== 16'h0000 || yaw_rt !== 16'h0000 || spi_if.cmd !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset_data: ptch=%h yaw=%h cmd=%h want 0000", ptch_rt, yaw_rt, spi_if.cmd);
    end
    step();
    step();
    nres = res_log.size();
    test_power_up(1'b0);
    total++;
    if (res_log.size() != nres || ptch_rt !== 16'h0000 || yaw_rt !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset_outputs: results=%0d ptch=%h yaw=%h want 0 0000 0000",
               res_log.size() - nres, ptch_rt, yaw_rt);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    cyc        = 0;
    glitch_req = 0;
    prev_out   = '0;
    prev_snd   = 1'b0;
    prev_vld   = 1'b0;
    rst        = 1'b1;
    INT        = 1'b0;
    lat_lo     = 40;
    lat_hi     = 40;
    test_reset();
    test_power_up(1'b1);
    lat_lo = 3;
    lat_hi = 10;
    test_read_known();
    test_random_reads();
    lat_lo = 4;
    test_back_to_back();
    test_done_level();
    lat_lo = 5;
    lat_hi = 5;
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
